// File: rtl/pit_intr_ctrl.sv
// Interrupt controller downstream of the PIT: edge-latched pending bits, per-source
// enables, a master enable and one registered level interrupt, on an IPIF-style slave bus.
module pit_intr_ctrl #(
   parameter int C_NUM_IRQ    = 4,
   parameter int C_SLV_DWIDTH = 32,
   parameter int C_NUM_REG    = 4
) (
   input  logic                      Bus2IP_Clk,
   input  logic                      Bus2IP_Resetn,
   input  logic [C_NUM_IRQ-1:0]      Intr_In,
   input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
   input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
   input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
   input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
   output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
   output logic                      IP2Bus_RdAck,
   output logic                      IP2Bus_WrAck,
   output logic                      IP2Bus_Error,
   output logic                      Irq
);

   // CE vectors are MSB-first: the top bit selects reg0.
   localparam int SEL_ISR = C_NUM_REG - 1;
   localparam int SEL_IER = C_NUM_REG - 2;
   localparam int SEL_IAR = C_NUM_REG - 3;
   localparam int SEL_MER = C_NUM_REG - 4;

   function automatic logic [C_SLV_DWIDTH-1:0] lane_mask(input logic [C_SLV_DWIDTH/8-1:0] be);
      logic [C_SLV_DWIDTH-1:0] m;
      m = {C_SLV_DWIDTH{1'b0}};
      for (int b = 0; b < C_SLV_DWIDTH/8; b++) begin
         m[b*8 +: 8] = {8{be[b]}};
      end
      return m;
   endfunction

   logic [C_NUM_IRQ-1:0]    isr_r;
   logic [C_NUM_IRQ-1:0]    ier_r;
   logic [C_NUM_IRQ-1:0]    intr_d_r;
   logic                    mer_r;
   logic                    irq_r;

   logic [C_SLV_DWIDTH-1:0] lane_s;
   logic [C_SLV_DWIDTH-1:0] set_bits_s;
   logic [C_SLV_DWIDTH-1:0] clr_bits_s;
   logic [C_NUM_IRQ-1:0]    rise_s;
   logic [C_NUM_IRQ-1:0]    iar_clr_s;
   logic [C_NUM_IRQ-1:0]    isr_wclr_s;
   logic [C_NUM_IRQ-1:0]    isr_next_s;
   logic [C_NUM_IRQ-1:0]    ier_next_s;
   logic [C_NUM_IRQ-1:0]    pend_s;
   logic                    mer_next_s;
   logic [C_SLV_DWIDTH-1:0] ivr_s;
   logic [C_SLV_DWIDTH-1:0] isr_ext_s;
   logic [C_SLV_DWIDTH-1:0] ier_ext_s;
   logic [C_SLV_DWIDTH-1:0] rd_data_s;
   logic                    unused_s;

   // Write decode and next-state of the software-visible registers.
   always_comb begin
      lane_s     = lane_mask(Bus2IP_BE);
      set_bits_s = Bus2IP_Data & lane_s;
      clr_bits_s = ~Bus2IP_Data & lane_s;
      rise_s     = Intr_In & ~intr_d_r;
      if (Bus2IP_WrCE[SEL_IAR]) begin
         iar_clr_s = set_bits_s[C_NUM_IRQ-1:0];
      end else begin
         iar_clr_s = {C_NUM_IRQ{1'b0}};
      end
      // Writing ISR can only clear: zero data bits in enabled lanes clear pending.
      if (Bus2IP_WrCE[SEL_ISR]) begin
         isr_wclr_s = clr_bits_s[C_NUM_IRQ-1:0];
      end else begin
         isr_wclr_s = {C_NUM_IRQ{1'b0}};
      end
      isr_next_s = (isr_r & ~iar_clr_s & ~isr_wclr_s) | rise_s;
      if (Bus2IP_WrCE[SEL_IER]) begin
         ier_next_s = (ier_r & ~lane_s[C_NUM_IRQ-1:0]) | set_bits_s[C_NUM_IRQ-1:0];
      end else begin
         ier_next_s = ier_r;
      end
      if (Bus2IP_WrCE[SEL_MER] && Bus2IP_BE[0]) begin
         mer_next_s = Bus2IP_Data[0];
      end else begin
         mer_next_s = mer_r;
      end
   end

   // Vector number: lowest enabled pending source, all ones when none or masked.
   always_comb begin
      pend_s = isr_r & ier_r;
      ivr_s  = {C_SLV_DWIDTH{1'b1}};
      for (int i = C_NUM_IRQ - 1; i >= 0; i--) begin
         ivr_s = pend_s[i] ? C_SLV_DWIDTH'(i) : ivr_s;
      end
      if (!mer_r) begin
         ivr_s = {C_SLV_DWIDTH{1'b1}};
      end else begin
         ivr_s = ivr_s;
      end
   end

   // Read mux of the selected register.
   always_comb begin
      isr_ext_s                 = {C_SLV_DWIDTH{1'b0}};
      isr_ext_s[C_NUM_IRQ-1:0]  = isr_r;
      ier_ext_s                 = {C_SLV_DWIDTH{1'b0}};
      ier_ext_s[C_NUM_IRQ-1:0]  = ier_r;
      case (Bus2IP_RdCE)
         4'b1000: rd_data_s = isr_ext_s;
         4'b0100: rd_data_s = ier_ext_s;
         4'b0010: rd_data_s = ivr_s;
         4'b0001: rd_data_s = {{(C_SLV_DWIDTH-1){1'b0}}, mer_r};
         default: rd_data_s = {C_SLV_DWIDTH{1'b0}};
      endcase
   end

   // Register state and the registered interrupt output.
   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
      if (!Bus2IP_Resetn) begin
         isr_r    <= {C_NUM_IRQ{1'b0}};
         ier_r    <= {C_NUM_IRQ{1'b0}};
         intr_d_r <= {C_NUM_IRQ{1'b0}};
         mer_r    <= 1'b0;
         irq_r    <= 1'b0;
      end else begin
         isr_r    <= isr_next_s;
         ier_r    <= ier_next_s;
         intr_d_r <= Intr_In;
         mer_r    <= mer_next_s;
         irq_r    <= mer_r & (|pend_s);
      end
   end

   assign unused_s     = ^{set_bits_s, clr_bits_s, lane_s};
   assign IP2Bus_Data  = rd_data_s;
   assign IP2Bus_RdAck = |Bus2IP_RdCE;
   assign IP2Bus_WrAck = |Bus2IP_WrCE;
   assign IP2Bus_Error = 1'b0;
   assign Irq          = irq_r;

endmodule

// File: tb/tb_pit_intr_ctrl.sv
// Self-checking bench for pit_intr_ctrl: directed vector table, hand-written
// reset sequences and randomized traffic against a behavioural model.
module tb_pit_intr_ctrl;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  intr = 4'h0;
   logic [3:0]  wrce = 4'h0;
   logic [3:0]  rdce = 4'h0;
   logic [3:0]  be = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        rdack, wrack, err, irq;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   bit [31:0] m_isr, m_ier;
   bit        m_mer, m_irq;
   bit [3:0]  m_prev;

   typedef struct {
      logic [3:0]  intr;
      logic [3:0]  wrce;
      logic [3:0]  rdce;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;
   vec_t vq[$];

   always #5 clk = ~clk;

   pit_intr_ctrl #(.C_NUM_IRQ(N), .C_SLV_DWIDTH(32), .C_NUM_REG(4)) dut (
      .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .Intr_In(intr),
      .Bus2IP_Data(wdata), .Bus2IP_BE(be), .Bus2IP_RdCE(rdce), .Bus2IP_WrCE(wrce),
      .IP2Bus_Data(rdata), .IP2Bus_RdAck(rdack), .IP2Bus_WrAck(wrack),
      .IP2Bus_Error(err), .Irq(irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: actual %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_isr = 0; m_ier = 0; m_mer = 0; m_irq = 0; m_prev = 0;
   endfunction

   function automatic bit [31:0] model_ivr();
      if (!m_mer) return 32'hFFFF_FFFF;
      for (int i = 0; i < N; i++)
         if (m_isr[i] && m_ier[i]) return i;
      return 32'hFFFF_FFFF;
   endfunction

   function automatic bit [31:0] model_read(input bit [3:0] r);
      case (r)
         4'b1000: return m_isr;
         4'b0100: return m_ier;
         4'b0010: return model_ivr();
         4'b0001: return {31'b0, m_mer};
         default: return 32'h0;
      endcase
   endfunction

   // One clock edge of the controller, from the register map rules.
   function automatic void model_edge(input bit [3:0] in, input bit [3:0] w,
                                      input bit [31:0] d, input bit [3:0] b);
      bit [31:0] lm, valid, rise;
      bit        new_irq;
      lm = 0;
      for (int k = 0; k < 4; k++) if (b[k]) lm |= 32'hFF << (8 * k);
      valid   = (32'h1 << N) - 1;
      rise    = {28'b0, in & ~m_prev};
      new_irq = m_mer && ((m_isr & m_ier) != 0);
      if (w == 4'b0010) m_isr &= ~(d & lm);
      if (w == 4'b1000) m_isr &= ~(~d & lm);
      m_isr = (m_isr | rise) & valid;
      if (w == 4'b0100) m_ier = ((m_ier & ~lm) | (d & lm)) & valid;
      if (w == 4'b0001 && b[0]) m_mer = d[0];
      m_prev = in;
      m_irq  = new_irq;
   endfunction

   task automatic cyc(input logic [3:0] in, input logic [3:0] w, input logic [3:0] r,
                      input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] rd_o, output logic irq_o);
      intr = in; wrce = w; rdce = r; wdata = d; be = b;
      #1;
      rd_o = rdata;
      chk("rd_data", rdata, model_read(r));
      chk("rd_ack", {31'b0, rdack}, {31'b0, |r});
      chk("wr_ack", {31'b0, wrack}, {31'b0, |w});
      chk("error", {31'b0, err}, 32'h0);
      @(posedge clk);
      model_edge(in, w, d, b);
      #1;
      irq_o = irq;
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
      intr = in; wrce = 4'h0; rdce = 4'h0; wdata = 32'h0; be = 4'h0;
   endtask

   function automatic void add(input logic [3:0] in, input logic [3:0] w, input logic [3:0] r,
                               input logic [31:0] d, input logic [3:0] b,
                               input logic [31:0] erd, input logic eirq);
      vec_t v;
      v = '{in, w, r, d, b, erd, eirq};
      vq.push_back(v);
   endfunction

   initial begin
      logic [31:0] rd, d;
      logic        iq;
      logic [3:0]  w, r, in, b;
      int          op;

      // reset reads
      add(4'h0, 4'h0, 4'h8, 32'h0, 4'h0, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h4, 32'h0, 4'h0, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h2, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0);
      add(4'h0, 4'h0, 4'h1, 32'h0, 4'h0, 32'h0, 1'b0);
      // PIT pulse path
      add(4'h0, 4'h4, 4'h0, 32'h1, 4'hF, 32'h0, 1'b0);
      add(4'h0, 4'h1, 4'h0, 32'h1, 4'hF, 32'h0, 1'b0);
      add(4'h1, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h8, 32'h0, 4'h0, 32'h1, 1'b1);
      add(4'h0, 4'h0, 4'h2, 32'h0, 4'h0, 32'h0, 1'b1);
      add(4'h0, 4'h2, 4'h0, 32'h1, 4'hF, 32'h0, 1'b1);
      add(4'h0, 4'h0, 4'h8, 32'h0, 4'h0, 32'h0, 1'b0);
      // masking and priority
      add(4'h0, 4'h4, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0);
      add(4'h6, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h8, 32'h0, 4'h0, 32'h6, 1'b0);
      add(4'h0, 4'h4, 4'h0, 32'h4, 4'hF, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h2, 32'h0, 4'h0, 32'h2, 1'b1);
      add(4'h0, 4'h4, 4'h0, 32'h6, 4'hF, 32'h0, 1'b1);
      add(4'h0, 4'h0, 4'h2, 32'h0, 4'h0, 32'h1, 1'b1);
      add(4'h0, 4'h1, 4'h0, 32'h0, 4'hF, 32'h0, 1'b1);
      add(4'h0, 4'h0, 4'h2, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0);
      // byte enables all off leave IER unchanged
      add(4'h0, 4'h4, 4'h0, 32'hF, 4'h0, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h4, 32'h0, 4'h0, 32'h6, 1'b0);
      // simultaneous rise and IAR clear on bit 3: set wins
      add(4'h8, 4'h2, 4'h0, 32'h8, 4'hF, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h8, 32'h0, 4'h0, 32'hE, 1'b0);
      // level held high for 10 cycles, cleared on the third
      add(4'h0, 4'h2, 4'h0, 32'hF, 4'hF, 32'h0, 1'b0);
      add(4'h1, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
      add(4'h1, 4'h0, 4'h8, 32'h0, 4'h0, 32'h1, 1'b0);
      add(4'h1, 4'h2, 4'h0, 32'h1, 4'hF, 32'h0, 1'b0);
      for (int i = 0; i < 7; i++) add(4'h1, 4'h0, 4'h8, 32'h0, 4'h0, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h8, 32'h0, 4'h0, 32'h0, 1'b0);
      add(4'h1, 4'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
      add(4'h0, 4'h0, 4'h8, 32'h0, 4'h0, 32'h1, 1'b0);

      // power-on reset
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("irq_in_reset", {31'b0, irq}, 32'h0);
      chk("rdata_in_reset", rdata, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         cyc(vq[i].intr, vq[i].wrce, vq[i].rdce, vq[i].data, vq[i].be, rd, iq);
         if (vq[i].rdce != 4'h0) chk($sformatf("vec%0d_rd", i), rd, vq[i].exp_rd);
         chk($sformatf("vec%0d_irq", i), {31'b0, iq}, {31'b0, vq[i].exp_irq});
      end

      // asynchronous reset in the middle of a cycle with Irq high
      cyc(4'h0, 4'h4, 4'h0, 32'h1, 4'hF, rd, iq);
      cyc(4'h0, 4'h1, 4'h0, 32'h1, 4'hF, rd, iq);
      cyc(4'h0, 4'h0, 4'h0, 32'h0, 4'h0, rd, iq);
      chk("irq_before_reset", {31'b0, iq}, 32'h1);
      #2 rst_n = 1'b0;
      #1 chk("irq_async_drop", {31'b0, irq}, 32'h0);
      #4 rst_n = 1'b1;
      model_reset();
      cyc(4'h0, 4'h0, 4'h8, 32'h0, 4'h0, rd, iq);
      chk("post_rst_isr", rd, 32'h0);
      cyc(4'h0, 4'h0, 4'h4, 32'h0, 4'h0, rd, iq);
      chk("post_rst_ier", rd, 32'h0);
      cyc(4'h0, 4'h0, 4'h2, 32'h0, 4'h0, rd, iq);
      chk("post_rst_ivr", rd, 32'hFFFF_FFFF);
      cyc(4'h0, 4'h0, 4'h1, 32'h0, 4'h0, rd, iq);
      chk("post_rst_mer", rd, 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         op = $urandom_range(0, 9);
         in = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         d  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         w  = 4'h0;
         r  = 4'h0;
         if (op < 3) w = 4'b1000 >> $urandom_range(0, 3);
         else if (op < 7) r = 4'b1000 >> $urandom_range(0, 3);
         if (w == 4'b0001) d[0] = ($urandom_range(0, 3) != 0);
         cyc(in, w, r, d, b, rd, iq);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
